// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, pixel type and helpers
package vga_pkg;

  // RGB444 pixel: three 4-bit channels packed {R,G,B}
  localparam int RGB_W = 4;
  localparam int PIX_W = 3 * RGB_W;

  // Both syncs are active-low for the 640x480 mode
  localparam logic SYNC_ACTIVE = 1'b0;

  // Default 640x480 timing, in pixels (horizontal) and lines (vertical)
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 11;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 31;

  typedef struct packed {
    logic [RGB_W-1:0] r;
    logic [RGB_W-1:0] g;
    logic [RGB_W-1:0] b;
  } rgb444_t;

  // Full period of one axis: visible + front porch + sync + back porch
  function automatic int timing_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous pixel FIFO with flush, power-of-two depth
module pixel_fifo import vga_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // Ready only reflects fullness, so a pop never lets a push into a full FIFO
  assign wr_ready = (count_q != FULL_COUNT);
  assign empty    = (count_q == '0);
  assign rd_data  = mem[rd_ptr_q];
  assign push     = wr_valid && wr_ready && !flush;
  assign pop      = rd_en && !empty && !flush;

  // Next pointers and occupancy; flush wins over any push or pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator and FIFO-fed RGB444 scanout
module vga_scanout import vga_pkg::*; #(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             CLOCK_50,
  input  logic             KEY,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic             frame_start,
  output logic             underflow,
  input  logic             underflow_clr,
  output logic [RGB_W-1:0] VGA_R,
  output logic [RGB_W-1:0] VGA_G,
  output logic [RGB_W-1:0] VGA_B,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_PIXEL_CLOCK
);

  localparam int H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEGIN  = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEGIN  = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  // Line just before the first vsync line; its last pixel triggers the flush
  localparam logic [VW-1:0] V_FLUSH   = VW'(V_VISIBLE + V_FRONT - 1);

  logic          phase_q, phase_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          pclk_q, pclk_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  rgb444_t       rgb_q, rgb_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;

  logic             pix_en, visible, flush;
  logic             fifo_empty;
  logic [PIX_W-1:0] fifo_rd_data;

  assign pix_en  = phase_q;
  assign visible = (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign flush   = pix_en && (h_q == H_LAST) && (v_q == V_FLUSH);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk      (CLOCK_50),
    .rst_n    (KEY),
    .flush    (flush),
    .wr_data  (pix_data),
    .wr_valid (pix_valid),
    .wr_ready (pix_ready),
    .rd_en    (pix_en && visible),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty)
  );

  // Next-state: counters step once per pixel; outputs lag the counters by one pixel
  always_comb begin
    phase_d = ~phase_q;
    pclk_d  = ~pix_en;
    h_d     = h_q;
    v_d     = v_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    rgb_d   = rgb_q;
    fs_d    = flush;
    uf_d    = (uf_q && !underflow_clr) || (pix_en && visible && fifo_empty);
    if (pix_en) begin
      hs_d  = ((h_q >= HS_BEGIN) && (h_q < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_d  = ((v_q >= VS_BEGIN) && (v_q < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      rgb_d = (visible && !fifo_empty) ? rgb444_t'(fifo_rd_data) : '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // State and registered VGA outputs
  always_ff @(posedge CLOCK_50 or negedge KEY) begin
    if (!KEY) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
      pclk_q  <= 1'b0;
      hs_q    <= ~SYNC_ACTIVE;
      vs_q    <= ~SYNC_ACTIVE;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pclk_q  <= pclk_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      rgb_q   <= rgb_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  assign VGA_R           = rgb_q.r;
  assign VGA_G           = rgb_q.g;
  assign VGA_B           = rgb_q.b;
  assign VGA_HS          = hs_q;
  assign VGA_VS          = vs_q;
  assign VGA_PIXEL_CLOCK = pclk_q;
  assign frame_start     = fs_q;
  assign underflow       = uf_q;

endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 11 / 2 / 31, vertical porch and sync widths in lines.
REQ-005 Parameter FIFO_DEPTH, default 16, pixel FIFO entries (power of two).
REQ-006 CLOCK_50  input  1  sole clock, 50 MHz.
REQ-007 KEY  input  1  reset, asynchronous, active-low.
REQ-008 pix_data  input  12  RGB444 pixel {R,G,B} from frame fetcher.
REQ-009 pix_valid  input  1  pix_data valid.
REQ-010 pix_ready  output  1  FIFO can accept; push when pix_valid and pix_ready high on a rising edge.
REQ-011 frame_start  output  1  one-cycle pulse requesting fetcher start the next frame.
REQ-012 underflow  output  1  sticky: visible pixel needed with FIFO empty.
REQ-013 underflow_clr  input  1  clears underflow.
REQ-014 VGA_R / VGA_G / VGA_B  output  4 each  pixel colour.
REQ-015 VGA_HS / VGA_VS  output  1 each  syncs, active-low.
REQ-016 VGA_PIXEL_CLOCK  output  1  25 MHz pixel clock.

Function
REQ-017 Internal pix_en shall be high every second CLOCK_50 cycle; VGA_PIXEL_CLOCK shall go low on pix_en edges, high on the others.
REQ-018 h_count shall advance by 1 per pix_en over 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), then wrap to 0 and advance v_count.
REQ-019 v_count shall range 0..V_TOTAL-1 (V_TOTAL = 524), wrapping to 0 after the last line.
REQ-020 Visible region: h_count < H_VISIBLE and v_count < V_VISIBLE.
REQ-021 VGA_HS low iff h_count in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC) (656..751).
REQ-022 VGA_VS low iff v_count in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC) (491..492).
REQ-023 All VGA outputs shall be registered, updating on pix_en edges, one pixel period after counters; HS, VS, RGB share this latency.
REQ-024 Visible position with FIFO non-empty: pop one entry on that pix_en edge; its R/G/B drive VGA_R/G/B.
REQ-025 Visible position with FIFO empty: RGB 0, no pop, underflow set.
REQ-026 Non-visible position: RGB 0, no pop.
REQ-027 FIFO: pix_ready = not full; simultaneous push and pop when full is disallowed (ready low); simultaneous push and pop when non-empty preserves count.
REQ-028 Pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
REQ-029 On the edge where v_count becomes V_VISIBLE+V_FRONT (first vsync line), h_count 0: FIFO flushed, frame_start pulsed one CLOCK_50 cycle; push that cycle dropped.
REQ-030 underflow_clr and new underflow same cycle: underflow stays 1.

Reset
REQ-031 KEY low asynchronously: h_count, v_count, pix_en phase 0; FIFO empty; pix_ready 1; frame_start 0; underflow 0; VGA_R/G/B 0; VGA_HS, VGA_VS 1; VGA_PIXEL_CLOCK 0.
REQ-032 Reset release: first pix_en on second rising CLOCK_50 edge; frame_start first pulses at v_count 491.
REQ-033 Reset mid-line/mid-frame shall abandon FIFO contents; no residual pixel output.

Structure
REQ-034 Timing constants (H/V totals, sync polarity, RGB444 width) in shared package vga_pkg, also used by bench vgasim setup.
REQ-035 FIFO as one sub-module, pixel_fifo (synchronous, FIFO_DEPTH x 12, flush input).

Verification
REQ-036 Reset then idle -> HS period 1600 CLOCK_50 cycles, HS low 192 cycles starting pixel 656; VS low exactly 2 lines at 491-492; RGB 0.
REQ-037 Push 16 pixels, no pop -> pix_ready low after 16th; 17th push refused, count stays 16.
REQ-038 Fetcher streams 0x000,0x001,... one frame -> pixel (x,y) shows value y*640+x mod 4096; underflow stays 0.
REQ-039 Fetcher stalls after 100 pixels of line 0 -> pixels 100..639 black; underflow 1; underflow_clr -> 0.
REQ-040 Run 3 frames -> exactly 3 frame_start pulses, spaced 419200 pixel periods (838400 CLOCK_50 cycles).
REQ-041 KEY low at h=300, v=200 with FIFO half full -> all outputs at reset values immediately; FIFO empty after release.
